// File: rtl/x_top_uart_mem_master_if.sv
// Byte stream and memory request signals between the UART bridge and its environment.
// master = bridge side, slave = UART/memory side.
interface x_top_uart_mem_master_if;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_accept;
    logic        o_rnw;
    logic        o_valid;
    logic        i_accept;
    logic [31:0] o_addr;
    logic [31:0] o_data;
    logic [31:0] i_data;
    logic        o_busy;

    modport master (
        input  i_rx_valid, i_rx_data, i_tx_accept, i_accept, i_data,
        output o_tx_valid, o_tx_data, o_rnw, o_valid, o_addr, o_data, o_busy
    );

    modport slave (
        output i_rx_valid, i_rx_data, i_tx_accept, i_accept, i_data,
        input  o_tx_valid, o_tx_data, o_rnw, o_valid, o_addr, o_data, o_busy
    );
endinterface

// File: rtl/x_top_uart_mem_master.sv
// UART byte commands (R/W + LE addr/data) to one mem request; o_valid one cycle after last byte, tx held until accepted, rx never stalled.
// X_UART_MEM_MASTER_TIMEOUT_EN adds an inter-byte timeout of p_timeout_cycles in ADDR/DATA.
module x_top_uart_mem_master #(
    parameter int unsigned p_timeout_cycles = 1000000
) (
    input logic                     i_clk,
    input logic                     i_rst,
    x_top_uart_mem_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, MEM, RESP} state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic        rnw;
    logic        valid;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [31:0] addr;
    logic [31:0] data;
    logic [23:0] resp;

    assign bus.o_rnw      = rnw;
    assign bus.o_valid    = valid;
    assign bus.o_addr     = addr;
    assign bus.o_data     = data;
    assign bus.o_tx_valid = tx_valid;
    assign bus.o_tx_data  = tx_data;
    assign bus.o_busy     = (state != IDLE);

`ifdef X_UART_MEM_MASTER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(p_timeout_cycles + 1);
    logic [TW-1:0] tcnt;
    logic          tmo;
    assign tmo = (tcnt == TW'(p_timeout_cycles));

    // Clears on every received byte and whenever outside ADDR/DATA, so entry starts at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tcnt <= '0;
        end else if ((state == ADDR || state == DATA) && !bus.i_rx_valid && !tmo) begin
            tcnt <= tcnt + 1'b1;
        end else begin
            tcnt <= '0;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            rnw      <= 1'b0;
            valid    <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            addr     <= 32'h0;
            data     <= 32'h0;
            resp     <= 24'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_rx_valid) begin
                        cnt <= 2'd0;
                        if (bus.i_rx_data == 8'h52) begin
                            rnw   <= 1'b1;
                            state <= ADDR;
                        end else if (bus.i_rx_data == 8'h57) begin
                            rnw   <= 1'b0;
                            state <= ADDR;
                        end else begin
                            tx_data  <= 8'h3F;
                            tx_valid <= 1'b1;
                            state    <= RESP;
                        end
                    end
                end
                ADDR: begin
                    if (bus.i_rx_valid) begin
                        addr[{cnt, 3'b000} +: 8] <= bus.i_rx_data;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            if (rnw) begin
                                valid <= 1'b1;
                                state <= MEM;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
`ifdef X_UART_MEM_MASTER_TIMEOUT_EN
                    else if (tmo) state <= IDLE;
`endif
                end
                DATA: begin
                    if (bus.i_rx_valid) begin
                        data[{cnt, 3'b000} +: 8] <= bus.i_rx_data;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            valid <= 1'b1;
                            state <= MEM;
                        end
                    end
`ifdef X_UART_MEM_MASTER_TIMEOUT_EN
                    else if (tmo) state <= IDLE;
`endif
                end
                MEM: begin
                    if (bus.i_accept) begin
                        valid    <= 1'b0;
                        tx_valid <= 1'b1;
                        state    <= RESP;
                        if (rnw) begin
                            tx_data <= bus.i_data[7:0];
                            resp    <= bus.i_data[31:8];
                            cnt     <= 2'd3;
                        end else begin
                            tx_data <= 8'h4B;
                            cnt     <= 2'd0;
                        end
                    end
                end
                RESP: begin
                    // cnt holds the number of bytes still queued behind the one on tx_data.
                    if (bus.i_tx_accept) begin
                        if (cnt == 2'd0) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            tx_data <= resp[7:0];
                            resp    <= {8'h00, resp[23:8]};
                            cnt     <= cnt - 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_x_top_uart_mem_master.sv
// Randomized bench for the UART-to-memory bridge with a queue-based scoreboard of mem requests and tx bytes.
`timescale 1ns/1ps
module tb_x_top_uart_mem_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    x_top_uart_mem_master_if bus();

    x_top_uart_mem_master #(.p_timeout_cycles(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        bit        rnw;
        bit [31:0] addr;
        bit [31:0] data;
    } req_t;

    req_t             req_q[$];
    bit [7:0]         tx_q[$];
    bit [7:0]         tx_log[$];
    int               nvec = 0;
    int               nerr = 0;
    int               acc_pct = 100;
    int               tx_pct = 100;
    bit               tx_stall2 = 1'b0;
    bit               fixed_en = 1'b0;
    logic [31:0]      fixed_dat = 32'h0;
    bit               mon_en = 1'b0;
    int               st = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: request and tx byte must match the head of the expected queues every cycle they are valid.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (bus.o_valid) begin
                if (req_q.size() == 0) begin
                    chk("req_unexpected", bus.o_valid, 1'b0);
                end else begin
                    chk("req_rnw", bus.o_rnw, req_q[0].rnw);
                    chk("req_addr", bus.o_addr, req_q[0].addr);
                    if (!req_q[0].rnw) chk("req_data", bus.o_data, req_q[0].data);
                    if (bus.i_accept) begin
                        if (req_q[0].rnw) begin
                            for (int k = 0; k < 4; k++) tx_q.push_back(bus.i_data[8*k +: 8]);
                        end else begin
                            tx_q.push_back(8'h4B);
                        end
                        req_q.delete(0);
                    end
                end
            end
            if (bus.o_tx_valid) begin
                if (tx_q.size() == 0) begin
                    chk("tx_unexpected", bus.o_tx_valid, 1'b0);
                end else begin
                    chk("tx_byte", bus.o_tx_data, tx_q[0]);
                    if (bus.i_tx_accept) begin
                        tx_log.push_back(bus.o_tx_data);
                        tx_q.delete(0);
                    end
                end
            end
        end
    end

    // Memory and transmitter responders.
    always @(posedge clk) begin
        #1;
        bus.i_accept = ($urandom_range(0, 99) < acc_pct);
        bus.i_data   = fixed_en ? fixed_dat : $urandom;
        if (tx_stall2) begin
            if (bus.o_tx_valid) begin
                if (st == 2) begin
                    bus.i_tx_accept = 1'b1;
                    st = 0;
                end else begin
                    bus.i_tx_accept = 1'b0;
                    st++;
                end
            end else begin
                bus.i_tx_accept = 1'b0;
                st = 0;
            end
        end else begin
            bus.i_tx_accept = ($urandom_range(0, 99) < tx_pct);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        tick();
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_read(input logic [31:0] a);
        req_q.push_back('{rnw: 1'b1, addr: a, data: 32'h0});
        send_byte(8'h52);
        for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8]);
        chk("rd_valid_rise", bus.o_valid, 1'b1);
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d);
        req_q.push_back('{rnw: 1'b0, addr: a, data: d});
        send_byte(8'h57);
        for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8]);
        for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8]);
        chk("wr_valid_rise", bus.o_valid, 1'b1);
    endtask

    task automatic send_bad(input logic [7:0] b);
        tx_q.push_back(8'h3F);
        send_byte(b);
        chk("bad_no_req", bus.o_valid, 1'b0);
    endtask

    // Bytes injected here land in MEM/RESP and must be dropped.
    task automatic wait_idle(input bit junk);
        for (int n = 0; n < 3000 && (bus.o_busy || tx_q.size() != 0 || req_q.size() != 0); n++) begin
            if (junk && bus.o_busy && $urandom_range(0, 3) == 0) begin
                bus.i_rx_valid = 1'b1;
                bus.i_rx_data  = 8'hAA;
            end
            tick();
            bus.i_rx_valid = 1'b0;
        end
        chk("idle_reached", bus.o_busy, 1'b0);
        chk("req_drained", req_q.size(), 0);
        chk("tx_drained", tx_q.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, bus.o_valid, 1'b0);
        chk({tag, "_tx_valid"}, bus.o_tx_valid, 1'b0);
        chk({tag, "_tx_data"}, bus.o_tx_data, 8'h00);
        chk({tag, "_rnw"}, bus.o_rnw, 1'b0);
        chk({tag, "_addr"}, bus.o_addr, 32'h0);
        chk({tag, "_data"}, bus.o_data, 32'h0);
        chk({tag, "_busy"}, bus.o_busy, 1'b0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        bus.i_rx_valid = 1'b0;
        tick();
        chk_zero("rst");
        req_q.delete();
        tx_q.delete();
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        bit [7:0] exp_rd[4];
        int kind;
        logic [31:0] a;
        logic [31:0] d;
        exp_rd = '{8'h78, 8'h56, 8'h34, 8'h12};

        bus.i_rx_valid  = 1'b0;
        bus.i_rx_data   = 8'h00;
        bus.i_tx_accept = 1'b0;
        bus.i_accept    = 1'b0;
        bus.i_data      = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("init");
        rst = 1'b0;
        mon_en = 1'b1;

        // Write with accept held off for three cycles.
        tx_log.delete();
        acc_pct = 0;
        send_write(32'h0000_0010, 32'hDEAD_BEEF);
        repeat (3) begin
            tick();
            chk("wr_hold_valid", bus.o_valid, 1'b1);
            chk("wr_hold_addr", bus.o_addr, 32'h0000_0010);
            chk("wr_hold_data", bus.o_data, 32'hDEAD_BEEF);
        end
        acc_pct = 100;
        wait_idle(1'b0);
        chk("wr_resp_len", tx_log.size(), 1);
        if (tx_log.size() == 1) chk("wr_resp_byte", tx_log[0], 8'h4B);

        // Read with fixed data and two stall cycles per tx byte.
        tx_log.delete();
        fixed_en = 1'b1;
        fixed_dat = 32'h1234_5678;
        tx_stall2 = 1'b1;
        send_read(32'h0000_0010);
        wait_idle(1'b0);
        chk("rd_resp_len", tx_log.size(), 4);
        for (int k = 0; k < 4 && k < tx_log.size(); k++) chk("rd_resp_byte", tx_log[k], exp_rd[k]);
        tx_stall2 = 1'b0;
        fixed_en = 1'b0;

        // Unknown command, then a normal read.
        tx_log.delete();
        send_bad(8'h41);
        wait_idle(1'b0);
        chk("bad_resp_len", tx_log.size(), 1);
        if (tx_log.size() == 1) chk("bad_resp_byte", tx_log[0], 8'h3F);
        send_read(32'h0000_0100);
        wait_idle(1'b0);

        // Junk byte while the request is held.
        acc_pct = 0;
        send_read(32'h0000_0200);
        send_byte(8'hAA);
        chk("junk_valid_held", bus.o_valid, 1'b1);
        acc_pct = 100;
        wait_idle(1'b1);
        send_write(32'h0000_0300, 32'hCAFE_F00D);
        wait_idle(1'b0);

        // Reset after two address bytes, then a fresh write to 0x4.
        send_byte(8'h57);
        send_byte(8'h04);
        send_byte(8'h00);
        do_reset();
        send_write(32'h0000_0004, 32'h0BAD_F00D);
        wait_idle(1'b0);

        // Reset while a read response is pending.
        tx_pct = 0;
        send_read(32'h0000_0020);
        for (int n = 0; n < 100 && !bus.o_tx_valid; n++) tick();
        chk("rst_resp_reached", bus.o_tx_valid, 1'b1);
        do_reset();
        tx_pct = 100;

`ifdef X_UART_MEM_MASTER_TIMEOUT_EN
        send_byte(8'h52);
        send_byte(8'h01);
        repeat (10) tick();
        chk("tmo_still_busy", bus.o_busy, 1'b1);
        repeat (10) tick();
        chk("tmo_idle", bus.o_busy, 1'b0);
        chk("tmo_no_tx", bus.o_tx_valid, 1'b0);
        send_read(32'h0000_0004);
        wait_idle(1'b0);
`endif

        // Randomized commands with random handshake rates and junk injection.
        for (int i = 0; i < 40; i++) begin
            acc_pct = $urandom_range(20, 100);
            tx_pct  = $urandom_range(20, 100);
            kind = $urandom_range(0, 9);
            a = $urandom;
            d = $urandom;
            if (kind < 4) begin
                send_read(a);
            end else if (kind < 9) begin
                send_write(a, d);
            end else begin
                d[7:0] = $urandom_range(0, 255);
                if (d[7:0] == 8'h52 || d[7:0] == 8'h57) d[7:0] = 8'h00;
                send_bad(d[7:0]);
            end
            wait_idle(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", nvec, nerr);
        $fatal(1);
    end
endmodule

// File: doc/x_top_uart_mem_master.md
Name: x_top_uart_mem_master

Overview:
UART-to-memory bridge that sits upstream of the memory-mapped UART peripheral's bus interface. It consumes received bytes from the UART receiver, parses read and write commands, and drives the mem valid/accept interface. It returns read data or a write acknowledge as bytes to the UART transmitter. It gives the host PC and the bench a byte-level debug/load path into the memory map.

Parameters:
p_timeout_cycles, 1000000, idle cycles allowed between bytes of one command; used only when X_UART_MEM_MASTER_TIMEOUT_EN is defined.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_rx_valid  in  1  single-cycle pulse; received byte present
i_rx_data  in  8  received byte
o_tx_valid  out  1  response byte valid
o_tx_data  out  8  response byte
i_tx_accept  in  1  transmitter takes byte
o_rnw  out  1  1 = read, 0 = write
o_valid  out  1  mem request valid
i_accept  in  1  mem request accepted
o_addr  out  32  mem address
o_data  out  32  mem write data
i_data  in  32  mem read data, valid in the i_accept cycle
o_busy  out  1  high whenever state != IDLE

Behaviour:
- Single clock i_clk. Reset i_rst is synchronous, active-high, sampled on the rising edge.
- Reset values: all outputs 0; state IDLE; byte counter 0; addr/data registers 0.
- Command format:
  - Read: 0x52 'R', then 4 address bytes, little-endian.
  - Write: 0x57 'W', then 4 address bytes LE, then 4 data bytes LE.
- Responses:
  - Read: 4 data bytes LE.
  - Write: single byte 0x4B 'K'.
  - Any other command byte: single byte 0x3F '?'.
- States:
  - IDLE: on i_rx_valid, latch rnw (R→1, W→0) and go to ADDR. Any other byte: load 0x3F and go to RESP.
  - ADDR: each i_rx_valid shifts the byte into o_addr[8k+7:8k], k = 0..3. After the 4th byte: read → MEM, write → DATA.
  - DATA: same scheme into o_data. After the 4th byte → MEM.
  - MEM: o_valid=1 with o_rnw/o_addr/o_data held stable. The transfer completes on the cycle o_valid & i_accept.
    - Read: capture i_data into the response register, count 4, go to RESP.
    - Write: load 0x4B, count 1, go to RESP.
    - o_valid deasserts the cycle after accept.
  - RESP: o_tx_valid=1, o_tx_data = current byte (read: LSB first). o_tx_data is held stable until i_tx_accept. Each accept advances to the next byte; after the last accept → IDLE.
- o_valid rises the cycle after the final command byte. No combinational path from any input to o_valid or o_tx_valid.
- Bytes arriving in MEM or RESP are discarded silently; there is no backpressure on rx.
- Byte counter is 2 bits and wraps 3→0 on the state change.
- Address is passed through unaligned; alignment is the slave's concern.
- Reset mid-command or mid-transfer: immediate return to IDLE, all outputs 0 next cycle, partial command lost.
- i_accept while o_valid=0 and i_tx_accept while o_tx_valid=0 are ignored.

Optional Feature:
Macro: X_UART_MEM_MASTER_TIMEOUT_EN.
- Defined:
  - A counter runs in ADDR/DATA. It clears on each i_rx_valid and on entry to those states.
  - When it reaches p_timeout_cycles, the FSM returns to IDLE, discards the partial command, and sends no response.
  - Counter width is $clog2(p_timeout_cycles+1).
- Undefined: no counter. ADDR/DATA wait indefinitely.

Test Plan:
- Write: rx 57 10 00 00 00 EF BE AD DE → one mem request o_rnw=0, o_addr=0x00000010, o_data=0xDEADBEEF. Hold i_accept low 3 cycles: request stable. After accept, tx byte 0x4B.
- Read: rx 52 10 00 00 00; i_accept with i_data=0x12345678 → o_rnw=1, o_addr=0x10. Tx bytes 78 56 34 12 in order. i_tx_accept stalls 2 cycles per byte with o_tx_data held.
- Bad command: rx 0x41 → tx 0x3F, no o_valid. A following valid read completes normally.
- Bytes during MEM/RESP: inject 0xAA while o_valid held → ignored. The next command parses correctly.
- Reset: assert i_rst after 2 address bytes → outputs 0 next cycle. A fresh write to 0x4 completes correctly.
- Timeout (macro defined, p_timeout_cycles=16): rx 52 01, then 20 idle cycles → back to IDLE, no response. Then rx 52 04 00 00 00 → read of 0x4.
